// File: rtl/video_mode_ctrl_pkg.sv
// video_modes_pkg: mode type, timing struct, mode table and FSM states shared by video_mode_ctrl.
//   mode_t      - 2-bit mode index (0=640x480, 1=800x600, 2=1280x1024, 3=reserved)
//   timing_t    - eight 12-bit horizontal/vertical timing fields
//   MODE_TABLE  - timing for each mode; mode_timing() looks it up
//   state_t     - mode-change sequencer states
package video_modes_pkg;

    typedef logic [1:0] mode_t;

    typedef struct packed {
        logic [11:0] h_fp;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [11:0] h_addr;
        logic [11:0] v_fp;
        logic [11:0] v_sync;
        logic [11:0] v_bp;
        logic [11:0] v_addr;
    } timing_t;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_EOF,
        ST_BLANK,
        ST_PLL_REQ,
        ST_PLL_REL,
        ST_LOAD,
        ST_RESTART
    } state_t;

    localparam mode_t MODE_RSVD = 2'd3;

    // Mode 3 is never loaded; its entry is zero.
    localparam timing_t MODE_TABLE [4] = '{
        '{12'd16, 12'd96,  12'd48,  12'd640,  12'd10, 12'd2, 12'd33, 12'd480},
        '{12'd40, 12'd128, 12'd88,  12'd800,  12'd1,  12'd4, 12'd23, 12'd600},
        '{12'd48, 12'd112, 12'd248, 12'd1280, 12'd1,  12'd3, 12'd38, 12'd1024},
        '{12'd0,  12'd0,   12'd0,   12'd0,    12'd0,  12'd0, 12'd0,  12'd0}
    };

    function automatic timing_t mode_timing(input mode_t m);
        return MODE_TABLE[m];
    endfunction

endpackage

// File: rtl/video_mode_ctrl_debounce.sv
// tumbler_debounce: 2-FF synchronizer for the tumblers plus a stability counter on the mode select.
//   i_clk, i_rst_n  - pixel clock, asynchronous active-low reset
//   i_tumblers      - raw switches; [1:0] mode select, [2] force blank
//   o_force_blank   - synchronized tumbler[2] (not debounced)
//   o_req_mode      - mode select after DEBOUNCE_CYCLES unchanged cycles
module tumbler_debounce
    import video_modes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter mode_t       RESET_MODE      = 2'd2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_tumblers,
    output logic       o_force_blank,
    output mode_t      o_req_mode
);

    localparam int unsigned D  = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
    localparam int unsigned CW = $clog2(D + 1);

    logic [2:0]    r_meta;
    logic [2:0]    r_sync;
    mode_t         r_last;
    mode_t         r_req;
    logic [CW-1:0] r_cnt;

    // Synchronizer and debouncer come out of reset already holding RESET_MODE
    // so releasing reset never looks like a mode request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= {1'b0, RESET_MODE};
            r_sync <= {1'b0, RESET_MODE};
            r_last <= RESET_MODE;
            r_req  <= RESET_MODE;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_tumblers;
            r_sync <= r_meta;
            if (r_sync[1:0] != r_last) begin
                r_last <= r_sync[1:0];
                r_cnt  <= '0;
            end else if (r_cnt == CW'(D - 1)) begin
                r_req <= r_last;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_force_blank = r_sync[2];
    assign o_req_mode    = r_req;

endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: sequences resolution changes (debounce, frame-aligned blanking, PLL handshake, timing reload).
//   i_pixel_clock, i_reset_n     - only clock, asynchronous active-low reset
//   i_tumblers                   - [1:0] mode select, [2] force blank
//   i_frame_end                  - end-of-visible-frame pulse from the timing generator
//   i_pll_ack / o_pll_req        - 4-phase PLL reconfiguration handshake, o_pll_mode valid with req
//   o_mode_id, o_h_*, o_v_*      - applied mode and its timing parameters
//   o_timing_rst, o_blank        - hold timing generator in reset, force RGB to zero
//   o_busy, o_pll_err            - sequence in progress, sticky PLL timeout
module video_mode_ctrl
    import video_modes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned PLL_TIMEOUT     = 1048576,
    parameter mode_t       RESET_MODE      = 2'd2
) (
    input  logic        i_pixel_clock,
    input  logic        i_reset_n,
    input  logic [2:0]  i_tumblers,
    input  logic        i_frame_end,
    input  logic        i_pll_ack,
    output logic        o_pll_req,
    output logic [1:0]  o_pll_mode,
    output logic [1:0]  o_mode_id,
    output logic [11:0] o_h_fp,
    output logic [11:0] o_h_sync,
    output logic [11:0] o_h_bp,
    output logic [11:0] o_h_addr,
    output logic [11:0] o_v_fp,
    output logic [11:0] o_v_sync,
    output logic [11:0] o_v_bp,
    output logic [11:0] o_v_addr,
    output logic        o_timing_rst,
    output logic        o_blank,
    output logic        o_busy,
    output logic        o_pll_err
);

    localparam int unsigned BLANK_N = (BLANK_FRAMES == 0) ? 1 : (BLANK_FRAMES > 256) ? 256 : BLANK_FRAMES;
    localparam int unsigned TMO_N   = (PLL_TIMEOUT == 0) ? 1 : PLL_TIMEOUT;
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_N - 1);
    localparam logic [20:0] TMO_LAST   = 21'(TMO_N - 1);

    logic    w_force_blank;
    mode_t   w_req_mode;
    logic    w_abort;

    state_t  r_state,  w_state_nxt;
    timing_t r_timing, w_timing_nxt;
    mode_t   r_mode_id, w_mode_id_nxt;
    mode_t   r_tgt,    w_tgt_nxt;
    logic    r_pll_err, w_pll_err_nxt;
    logic [7:0]  r_bcnt, w_bcnt_nxt;
    logic [20:0] r_tcnt, w_tcnt_nxt;
    logic    r_pll_req;
    logic    r_timing_rst;
    logic    r_blank;
    logic    r_busy;

    tumbler_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_MODE     (RESET_MODE)
    ) u_debounce (
        .i_clk        (i_pixel_clock),
        .i_rst_n      (i_reset_n),
        .i_tumblers   (i_tumblers),
        .o_force_blank(w_force_blank),
        .o_req_mode   (w_req_mode)
    );

    // No change wanted: either already applied or the reserved mode.
    assign w_abort = (w_req_mode == r_mode_id) || (w_req_mode == MODE_RSVD);

    always_comb begin
        w_state_nxt   = r_state;
        w_timing_nxt  = r_timing;
        w_mode_id_nxt = r_mode_id;
        w_tgt_nxt     = r_tgt;
        w_pll_err_nxt = r_pll_err;
        w_bcnt_nxt    = r_bcnt;
        w_tcnt_nxt    = r_tcnt;
        case (r_state)
            ST_RUN: begin
                if (!w_abort) w_state_nxt = ST_WAIT_EOF;
            end
            ST_WAIT_EOF: begin
                if (w_abort) begin
                    w_state_nxt = ST_RUN;
                end else if (i_frame_end) begin
                    w_state_nxt = ST_BLANK;
                    w_bcnt_nxt  = '0;
                    w_tgt_nxt   = w_req_mode;
                end
            end
            ST_BLANK: begin
                if (i_frame_end) begin
                    if (r_bcnt == BLANK_LAST) begin
                        w_state_nxt = ST_PLL_REQ;
                        w_tcnt_nxt  = '0;
                        // Keep the last valid request if the tumblers moved to the reserved mode.
                        w_tgt_nxt   = (w_req_mode == MODE_RSVD) ? r_tgt : w_req_mode;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 8'd1;
                    end
                end
            end
            ST_PLL_REQ: begin
                if (i_pll_ack) begin
                    w_state_nxt = ST_PLL_REL;
                    w_tcnt_nxt  = '0;
                end else if (r_tcnt == TMO_LAST) begin
                    w_state_nxt   = ST_RESTART;
                    w_pll_err_nxt = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + 21'd1;
                end
            end
            ST_PLL_REL: begin
                // Timing is loaded on entry to LOAD so it changes while timing_rst is still high.
                if (!i_pll_ack) begin
                    w_state_nxt   = ST_LOAD;
                    w_timing_nxt  = mode_timing(r_tgt);
                    w_mode_id_nxt = r_tgt;
                end else if (r_tcnt == TMO_LAST) begin
                    w_state_nxt   = ST_RESTART;
                    w_pll_err_nxt = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + 21'd1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RESTART;
            end
            ST_RESTART: begin
                if (i_frame_end) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RESTART;
            end
        endcase
    end

    // Output flags are registered from the next state so they line up with the state register.
    always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_RESTART;
            r_timing     <= mode_timing(RESET_MODE);
            r_mode_id    <= RESET_MODE;
            r_tgt        <= RESET_MODE;
            r_pll_err    <= 1'b0;
            r_bcnt       <= '0;
            r_tcnt       <= '0;
            r_pll_req    <= 1'b0;
            r_timing_rst <= 1'b0;
            r_blank      <= 1'b1;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_timing     <= w_timing_nxt;
            r_mode_id    <= w_mode_id_nxt;
            r_tgt        <= w_tgt_nxt;
            r_pll_err    <= w_pll_err_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_pll_req    <= (w_state_nxt == ST_PLL_REQ);
            r_timing_rst <= (w_state_nxt == ST_PLL_REQ) || (w_state_nxt == ST_PLL_REL) || (w_state_nxt == ST_LOAD);
            r_blank      <= (w_state_nxt == ST_RUN || w_state_nxt == ST_WAIT_EOF) ? w_force_blank : 1'b1;
            r_busy       <= (w_state_nxt != ST_RUN);
        end
    end

    assign o_pll_req    = r_pll_req;
    assign o_pll_mode   = r_tgt;
    assign o_mode_id    = r_mode_id;
    assign o_h_fp       = r_timing.h_fp;
    assign o_h_sync     = r_timing.h_sync;
    assign o_h_bp       = r_timing.h_bp;
    assign o_h_addr     = r_timing.h_addr;
    assign o_v_fp       = r_timing.v_fp;
    assign o_v_sync     = r_timing.v_sync;
    assign o_v_bp       = r_timing.v_bp;
    assign o_v_addr     = r_timing.v_addr;
    assign o_timing_rst = r_timing_rst;
    assign o_blank      = r_blank;
    assign o_busy       = r_busy;
    assign o_pll_err    = r_pll_err;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: scoreboard bench for video_mode_ctrl with a responsive PLL model.
module tb_video_mode_ctrl;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] h;
        logic [11:0] v;
        logic        err;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  tumblers;
    logic        frame_end;
    logic        pll_ack;
    logic        pll_req;
    logic [1:0]  pll_mode;
    logic [1:0]  mode_id;
    logic [11:0] h_fp, h_sync, h_bp, h_addr, v_fp, v_sync, v_bp, v_addr;
    logic        timing_rst, blank, busy, pll_err;

    int          n_total = 0;
    int          n_bad = 0;
    done_t       q_done[$];
    logic [1:0]  q_pll[$];
    logic        prev_req, prev_busy;
    logic [1:0]  prev_mode;
    logic [11:0] prev_h, prev_v;
    logic        ack_en;
    int          ack_cnt;

    always #5 clk = ~clk;

    video_mode_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .BLANK_FRAMES   (2),
        .PLL_TIMEOUT    (100),
        .RESET_MODE     (2'd2)
    ) dut (
        .i_pixel_clock(clk),
        .i_reset_n    (rst_n),
        .i_tumblers   (tumblers),
        .i_frame_end  (frame_end),
        .i_pll_ack    (pll_ack),
        .o_pll_req    (pll_req),
        .o_pll_mode   (pll_mode),
        .o_mode_id    (mode_id),
        .o_h_fp       (h_fp),
        .o_h_sync     (h_sync),
        .o_h_bp       (h_bp),
        .o_h_addr     (h_addr),
        .o_v_fp       (v_fp),
        .o_v_sync     (v_sync),
        .o_v_bp       (v_bp),
        .o_v_addr     (v_addr),
        .o_timing_rst (timing_rst),
        .o_blank      (blank),
        .o_busy       (busy),
        .o_pll_err    (pll_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // One cycle: sample at negedge, run scoreboard monitors and the PLL model.
    task automatic tick();
        done_t d;
        @(negedge clk);
        if (pll_req && !prev_req) begin
            chk("pll_req_expected", 32'(q_pll.size() != 0), 1);
            if (q_pll.size() != 0) chk("pll_mode", 32'(pll_mode), 32'(q_pll.pop_front()));
            chk("trst_with_req", 32'(timing_rst), 1);
        end
        if (prev_req) chk("pll_mode_hold", 32'(pll_mode), 32'(prev_mode));
        if (h_addr != prev_h || v_addr != prev_v) chk("trst_on_load", 32'(timing_rst), 1);
        if (prev_busy && !busy) begin
            chk("done_expected", 32'(q_done.size() != 0), 1);
            if (q_done.size() != 0) begin
                d = q_done.pop_front();
                chk("done_mode", 32'(mode_id), 32'(d.mode));
                chk("done_h_addr", 32'(h_addr), 32'(d.h));
                chk("done_v_addr", 32'(v_addr), 32'(d.v));
                chk("done_pll_err", 32'(pll_err), 32'(d.err));
            end
        end
        if (ack_en) begin
            if (pll_req && !pll_ack) begin
                ack_cnt++;
                if (ack_cnt >= 5) pll_ack = 1'b1;
            end else if (!pll_req && pll_ack) begin
                pll_ack = 1'b0;
                ack_cnt = 0;
            end
        end
        prev_req  = pll_req;
        prev_busy = busy;
        prev_mode = pll_mode;
        prev_h    = h_addr;
        prev_v    = v_addr;
    endtask

    task automatic frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_busy(input string tag, input logic v);
        int n = 0;
        while (busy !== v && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'(v));
    endtask

    task automatic push_done(input logic [1:0] m, input logic [11:0] h, input logic [11:0] v, input logic e);
        done_t d;
        d.mode = m; d.h = h; d.v = v; d.err = e;
        q_done.push_back(d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_b, seen_r;
        int   n;
        rst_n = 1'b0; tumblers = 3'b010; frame_end = 1'b0; pll_ack = 1'b0;
        ack_en = 1'b1; ack_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_mode_id", 32'(mode_id), 2);
        chk("rst_h_fp", 32'(h_fp), 48);
        chk("rst_h_sync", 32'(h_sync), 112);
        chk("rst_h_bp", 32'(h_bp), 248);
        chk("rst_h_addr", 32'(h_addr), 1280);
        chk("rst_v_fp", 32'(v_fp), 1);
        chk("rst_v_sync", 32'(v_sync), 3);
        chk("rst_v_bp", 32'(v_bp), 38);
        chk("rst_v_addr", 32'(v_addr), 1024);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_trst", 32'(timing_rst), 0);
        chk("rst_pll_req", 32'(pll_req), 0);
        chk("rst_pll_mode", 32'(pll_mode), 2);
        chk("rst_pll_err", 32'(pll_err), 0);
        prev_req = 0; prev_busy = busy; prev_mode = pll_mode; prev_h = h_addr; prev_v = v_addr;
        rst_n = 1'b1;
        repeat (30) tick();
        chk("restart_busy", 32'(busy), 1);
        chk("restart_blank", 32'(blank), 1);
        push_done(2'd2, 12'd1280, 12'd1024, 1'b0);
        frame();
        chk("first_run_busy", 32'(busy), 0);
        chk("first_run_blank", 32'(blank), 0);

        // 2 -> 0 with a responsive PLL
        q_pll.push_back(2'd0);
        push_done(2'd0, 12'd640, 12'd480, 1'b0);
        tumblers = 3'b000;
        wait_busy("m0_busy", 1'b1);
        chk("m0_wait_blank", 32'(blank), 0);
        frame();
        chk("m0_blank", 32'(blank), 1);
        frame();
        chk("m0_req_early", 32'(pll_req), 0);
        frame();
        chk("m0_req", 32'(pll_req), 1);
        repeat (20) tick();
        chk("m0_h_fp", 32'(h_fp), 16);
        chk("m0_h_sync", 32'(h_sync), 96);
        chk("m0_h_bp", 32'(h_bp), 48);
        chk("m0_h_addr", 32'(h_addr), 640);
        chk("m0_v_fp", 32'(v_fp), 10);
        chk("m0_v_sync", 32'(v_sync), 2);
        chk("m0_v_bp", 32'(v_bp), 33);
        chk("m0_v_addr", 32'(v_addr), 480);
        chk("m0_mode_id", 32'(mode_id), 0);
        chk("m0_trst_low", 32'(timing_rst), 0);
        chk("m0_restart_busy", 32'(busy), 1);
        frame();
        chk("m0_run_busy", 32'(busy), 0);
        chk("m0_run_blank", 32'(blank), 0);

        // glitch shorter than the debounce window
        tumblers = 3'b001;
        seen_b = 0;
        repeat (10) begin tick(); seen_b |= busy; end
        tumblers = 3'b000;
        repeat (30) begin tick(); seen_b |= busy; end
        chk("glitch_busy", 32'(seen_b), 0);
        chk("glitch_mode", 32'(mode_id), 0);

        // request then revert before any frame_end
        push_done(2'd0, 12'd640, 12'd480, 1'b0);
        tumblers = 3'b001;
        wait_busy("abort_busy", 1'b1);
        tumblers = 3'b000;
        seen_b = 0; seen_r = 0;
        repeat (40) begin tick(); seen_b |= blank; seen_r |= pll_req; end
        chk("abort_blank", 32'(seen_b), 0);
        chk("abort_req", 32'(seen_r), 0);
        chk("abort_idle", 32'(busy), 0);

        // PLL never acks: timeout after 100 cycles
        ack_en = 1'b0;
        q_pll.push_back(2'd1);
        push_done(2'd0, 12'd640, 12'd480, 1'b1);
        tumblers = 3'b001;
        wait_busy("tmo_busy", 1'b1);
        frame(); frame(); frame();
        chk("tmo_req", 32'(pll_req), 1);
        n = 0;
        while (!pll_err && n < 200) begin tick(); n++; end
        chk("tmo_cycles", 32'(n), 100);
        chk("tmo_req_drop", 32'(pll_req), 0);
        chk("tmo_mode_kept", 32'(mode_id), 0);
        chk("tmo_h_kept", 32'(h_addr), 640);
        chk("tmo_trst", 32'(timing_rst), 0);
        chk("tmo_blank", 32'(blank), 1);
        tumblers = 3'b000;
        repeat (25) tick();
        frame();
        chk("tmo_run", 32'(busy), 0);
        chk("tmo_err_sticky", 32'(pll_err), 1);
        ack_en = 1'b1;

        // 0 -> 2, frame_end during PLL_REQ is ignored
        q_pll.push_back(2'd2);
        push_done(2'd2, 12'd1280, 12'd1024, 1'b1);
        tumblers = 3'b010;
        wait_busy("m2_busy", 1'b1);
        frame(); frame(); frame();
        frame();
        chk("m2_fe_ignored", 32'(pll_req), 1);
        repeat (20) tick();
        chk("m2_h_addr", 32'(h_addr), 1280);
        chk("m2_v_addr", 32'(v_addr), 1024);
        chk("m2_mode_id", 32'(mode_id), 2);
        frame();
        chk("m2_run", 32'(busy), 0);

        // reserved mode is ignored
        tumblers = 3'b011;
        seen_b = 0;
        repeat (40) begin tick(); seen_b |= busy; end
        chk("m3_ignored", 32'(seen_b), 0);
        chk("m3_mode", 32'(mode_id), 2);

        // forced blank through the synchronizer
        tumblers = 3'b110;
        repeat (30) tick();
        tumblers = 3'b010;
        repeat (30) tick();
        tumblers = 3'b110;
        tick(); tick();
        chk("fb_2cyc", 32'(blank), 0);
        tick();
        chk("fb_3cyc", 32'(blank), 1);
        tumblers = 3'b010;
        repeat (3) tick();
        chk("fb_release", 32'(blank), 0);

        // async reset mid-handshake withdraws the request
        q_pll.push_back(2'd0);
        tumblers = 3'b000;
        wait_busy("ar_busy", 1'b1);
        frame(); frame(); frame();
        chk("ar_req", 32'(pll_req), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_req_drop", 32'(pll_req), 0);
        chk("ar_mode", 32'(mode_id), 2);
        chk("ar_err_clr", 32'(pll_err), 0);
        chk("ar_blank", 32'(blank), 1);
        chk("ar_trst", 32'(timing_rst), 0);
        chk("ar_done_drained", 32'(q_done.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
